// File: rtl/main_control_fsm.sv
// main_control_fsm: multicycle Moore control unit sequencing fetch, decode, execute, memory, writeback and exceptions
module main_control_fsm #(
  parameter int         MEM_WAIT    = 2,
  parameter logic [2:0] EXC_VEC_SEL = 3'b101
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Overflow,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       EQorNE,
  output logic [2:0] IorD,
  output logic       MemRead_Write,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [3:0] MemtoReg,
  output logic       RegALoad,
  output logic       RegBLoad,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic       ALUOutLoad,
  output logic       EPCWrite,
  output logic [2:0] PCSrc,
  output logic       ExcCause,
  output logic [4:0] State
);
  typedef enum logic [4:0] {
    S_RESET, S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I, S_ADDR,
    S_MEM_RD, S_WB_LW, S_MEM_WR, S_BRANCH, S_JUMP, S_EXC1, S_EXC2
  } state_t;
  localparam logic [1:0] LAST = MEM_WAIT[1:0];
  state_t     state, next;
  logic [1:0] cnt;
  logic       cause;
  logic       done;
  logic       r_ok;
  assign done  = cnt == LAST;
  assign r_ok  = Funct == 6'h20 || Funct == 6'h22 || Funct == 6'h24;
  assign State = state;
  // state register; wait counter restarts whenever the state changes; cause latched on entry to EXC1
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_RESET;
      cnt   <= '0;
      cause <= 1'b0;
    end else begin
      state <= next;
      cnt   <= (next == state) ? cnt + 2'd1 : '0;
      if (next == S_EXC1 && state != S_EXC1) cause <= state == S_DECODE;
    end
  end
  // next-state and Moore output decode, everything defaulting to 0
  always_comb begin
    next          = state;
    PCWrite       = 1'b0;
    PCWriteCond   = 1'b0;
    EQorNE        = 1'b0;
    IorD          = 3'b000;
    MemRead_Write = 1'b0;
    IRWrite       = 1'b0;
    RegWrite      = 1'b0;
    RegDst        = 2'b00;
    MemtoReg      = 4'b0000;
    RegALoad      = 1'b0;
    RegBLoad      = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    ALUOp         = 3'b000;
    ALUOutLoad    = 1'b0;
    EPCWrite      = 1'b0;
    PCSrc         = 3'b000;
    ExcCause      = 1'b0;
    case (state)
      S_RESET: next = S_FETCH;
      S_FETCH: begin
        next    = done ? S_DECODE : S_FETCH;
        IRWrite = done;
        PCWrite = done;
        ALUSrcB = done ? 2'b01 : 2'b00;
        ALUOp   = done ? 3'b001 : 3'b000;
      end
      S_DECODE: begin
        RegALoad   = 1'b1;
        RegBLoad   = 1'b1;
        ALUSrcB    = 2'b11;
        ALUOp      = 3'b001;
        ALUOutLoad = 1'b1;
        next = (Opcode == 6'h00) ? (r_ok ? S_EXEC_R : S_EXC1) :
               (Opcode == 6'h08) ? S_EXEC_I :
               (Opcode == 6'h23 || Opcode == 6'h2B) ? S_ADDR :
               (Opcode == 6'h04 || Opcode == 6'h05) ? S_BRANCH :
               (Opcode == 6'h02) ? S_JUMP : S_EXC1;
      end
      S_EXEC_R: begin
        ALUSrcA    = 1'b1;
        ALUOp      = (Funct == 6'h22) ? 3'b010 : (Funct == 6'h24) ? 3'b011 : 3'b001;
        ALUOutLoad = 1'b1;
        next       = (Overflow && Funct != 6'h24) ? S_EXC1 : S_WB_R;
      end
      S_WB_R: begin
        RegDst   = 2'b01;
        RegWrite = 1'b1;
        next     = S_FETCH;
      end
      S_EXEC_I, S_ADDR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ALUOp      = 3'b001;
        ALUOutLoad = 1'b1;
        next = (state == S_EXEC_I) ? (Overflow ? S_EXC1 : S_WB_I) :
               (Opcode == 6'h23) ? S_MEM_RD : S_MEM_WR;
      end
      S_WB_I: begin
        RegWrite = 1'b1;
        next     = S_FETCH;
      end
      S_MEM_RD: begin
        IorD = 3'b001;
        next = done ? S_WB_LW : S_MEM_RD;
      end
      S_WB_LW: begin
        MemtoReg = 4'b0001;
        RegWrite = 1'b1;
        next     = S_FETCH;
      end
      S_MEM_WR: begin
        IorD          = 3'b001;
        MemRead_Write = 1'b1;
        next          = done ? S_FETCH : S_MEM_WR;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 3'b111;
        PCSrc       = 3'b001;
        PCWriteCond = 1'b1;
        EQorNE      = Opcode[0];
        next        = S_FETCH;
      end
      S_JUMP: begin
        PCSrc   = 3'b010;
        PCWrite = 1'b1;
        next    = S_FETCH;
      end
      S_EXC1: begin
        ALUSrcB  = 2'b01;
        ALUOp    = 3'b010;
        EPCWrite = 1'b1;
        next     = S_EXC2;
      end
      S_EXC2: begin
        PCSrc    = EXC_VEC_SEL;
        PCWrite  = 1'b1;
        ExcCause = cause;
        next     = S_FETCH;
      end
      default: next = S_RESET;
    endcase
  end
endmodule

// File: tb/tb_main_control_fsm.sv
// tb_main_control_fsm: directed per-scenario checks of the main control FSM with MEM_WAIT=2
module tb_main_control_fsm;
  localparam logic [4:0] RST = 5'd0, F = 5'd1, D = 5'd2, ER = 5'd3, WR = 5'd4, EI = 5'd5,
                         AD = 5'd7, MR = 5'd8, WL = 5'd9, MW = 5'd10, BR = 5'd11, JP = 5'd12,
                         X1 = 5'd13, X2 = 5'd14;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] Opcode = 6'h02;
  logic [5:0] Funct = 6'h00;
  logic       Overflow = 1'b0;
  logic       PCWrite, PCWriteCond, EQorNE, MemRead_Write, IRWrite, RegWrite;
  logic       RegALoad, RegBLoad, ALUSrcA, ALUOutLoad, EPCWrite, ExcCause;
  logic [2:0] IorD, ALUOp, PCSrc;
  logic [1:0] RegDst, ALUSrcB;
  logic [3:0] MemtoReg;
  logic [4:0] State;
  int tests = 0;
  int fails = 0;
  main_control_fsm dut (
    .clk(clk), .rst(rst), .Opcode(Opcode), .Funct(Funct), .Overflow(Overflow),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .EQorNE(EQorNE), .IorD(IorD),
    .MemRead_Write(MemRead_Write), .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegALoad(RegALoad), .RegBLoad(RegBLoad), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ALUOutLoad(ALUOutLoad), .EPCWrite(EPCWrite),
    .PCSrc(PCSrc), .ExcCause(ExcCause), .State(State)
  );
  always #5 clk = ~clk;
  wire [8:0] strobes = {PCWrite, PCWriteCond, MemRead_Write, IRWrite, RegWrite,
                        RegALoad, RegBLoad, ALUOutLoad, EPCWrite};
  // reset, release, one clean fetch, then a jump to land back at FETCH
  task automatic test_reset();
    logic [4:0] seq [5] = '{F, F, F, D, JP};
    rst = 1'b0;
    Opcode = 6'h02;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests++;
      if (State !== RST || strobes !== 9'd0) begin
        fails++;
        $display("FAIL reset[%0d] state=%0d strobes=%b expected state=0 strobes=0", i, State, strobes);
      end
    end
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if (State !== seq[i] || IRWrite !== (i == 2) || (i < 3 && PCWrite !== (i == 2))) begin
        fails++;
        $display("FAIL reset_fetch[%0d] state=%0d ir=%b pc=%b expected state=%0d ir=%b", i, State, IRWrite, PCWrite, seq[i], i == 2);
      end
      if (i == 2) begin
        tests++;
        if (ALUSrcB !== 2'b01 || ALUOp !== 3'b001 || IorD !== 3'b000 || PCSrc !== 3'b000) begin
          fails++;
          $display("FAIL fetch_last srcb=%b op=%b iord=%b pcsrc=%b expected 01 001 000 000", ALUSrcB, ALUOp, IorD, PCSrc);
        end
      end
      if (i == 3) begin
        tests++;
        if (!RegALoad || !RegBLoad || !ALUOutLoad || ALUSrcB !== 2'b11 || ALUOp !== 3'b001) begin
          fails++;
          $display("FAIL decode a=%b b=%b ao=%b srcb=%b op=%b expected 1 1 1 11 001", RegALoad, RegBLoad, ALUOutLoad, ALUSrcB, ALUOp);
        end
      end
      if (i == 4) begin
        tests++;
        if (PCWrite !== 1'b1 || PCSrc !== 3'b010) begin
          fails++;
          $display("FAIL jump pcw=%b pcsrc=%b expected 1 010", PCWrite, PCSrc);
        end
      end
    end
  endtask
  // R-type add/and: and ignores Overflow
  task automatic test_rtype(input logic [5:0] fn, input logic ovf, input logic [2:0] op);
    logic [4:0] seq [6] = '{F, F, F, D, ER, WR};
    Opcode = 6'h00;
    Funct = fn;
    Overflow = ovf;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      tests++;
      if (State !== seq[i] || RegWrite !== (i == 5)) begin
        fails++;
        $display("FAIL rtype_%h[%0d] state=%0d rw=%b expected state=%0d rw=%b", fn, i, State, RegWrite, seq[i], i == 5);
      end
      if (i == 4) begin
        tests++;
        if (ALUOp !== op || ALUSrcA !== 1'b1 || ALUSrcB !== 2'b00 || !ALUOutLoad) begin
          fails++;
          $display("FAIL exec_r_%h op=%b srca=%b srcb=%b expected op=%b srca=1 srcb=00", fn, ALUOp, ALUSrcA, ALUSrcB, op);
        end
      end
      if (i == 5) begin
        tests++;
        if (RegDst !== 2'b01 || MemtoReg !== 4'b0000) begin
          fails++;
          $display("FAIL wb_r dst=%b m2r=%b expected 01 0000", RegDst, MemtoReg);
        end
      end
    end
    Overflow = 1'b0;
  endtask
  // addi overflow trap and invalid opcode trap
  task automatic test_exception(input logic [5:0] opc, input logic ovf, input logic cause);
    logic [4:0] seq [7];
    int n;
    seq = ovf ? '{F, F, F, D, EI, X1, X2} : '{F, F, F, D, X1, X2, F};
    n = ovf ? 7 : 6;
    Opcode = opc;
    Overflow = ovf;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tests++;
      if (State !== seq[i] || RegWrite !== 1'b0) begin
        fails++;
        $display("FAIL exc_%h[%0d] state=%0d rw=%b expected state=%0d rw=0", opc, i, State, RegWrite, seq[i]);
      end
      if (i == n - 2) begin
        tests++;
        if (EPCWrite !== 1'b1 || ALUOp !== 3'b010 || ALUSrcB !== 2'b01 || ALUSrcA !== 1'b0) begin
          fails++;
          $display("FAIL exc1_%h epc=%b op=%b srcb=%b expected 1 010 01", opc, EPCWrite, ALUOp, ALUSrcB);
        end
      end
      if (i == n - 1) begin
        tests++;
        if (PCWrite !== 1'b1 || PCSrc !== 3'b101 || ExcCause !== cause) begin
          fails++;
          $display("FAIL exc2_%h pcw=%b pcsrc=%b cause=%b expected 1 101 %b", opc, PCWrite, PCSrc, ExcCause, cause);
        end
      end
    end
    Overflow = 1'b0;
  endtask
  // lw: three MEM_RD cycles then WB_LW; sw: three write cycles, no register write
  task automatic test_mem();
    logic [4:0] lw_seq [9] = '{F, F, F, D, AD, MR, MR, MR, WL};
    logic [4:0] sw_seq [8] = '{F, F, F, D, AD, MW, MW, MW};
    Opcode = 6'h23;
    Overflow = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      tests++;
      if (State !== lw_seq[i] || IorD !== ((i >= 5 && i <= 7) ? 3'b001 : 3'b000) || MemRead_Write !== 1'b0 || RegWrite !== (i == 8)) begin
        fails++;
        $display("FAIL lw[%0d] state=%0d iord=%b mrw=%b rw=%b expected state=%0d", i, State, IorD, MemRead_Write, RegWrite, lw_seq[i]);
      end
      if (i == 8) begin
        tests++;
        if (MemtoReg !== 4'b0001 || RegDst !== 2'b00) begin
          fails++;
          $display("FAIL wb_lw m2r=%b dst=%b expected 0001 00", MemtoReg, RegDst);
        end
      end
    end
    Overflow = 1'b0;
    Opcode = 6'h2B;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      tests++;
      if (State !== sw_seq[i] || MemRead_Write !== (i >= 5) || RegWrite !== 1'b0 || (i >= 5 && IorD !== 3'b001)) begin
        fails++;
        $display("FAIL sw[%0d] state=%0d mrw=%b rw=%b iord=%b expected state=%0d mrw=%b", i, State, MemRead_Write, RegWrite, IorD, sw_seq[i], i >= 5);
      end
    end
  endtask
  // bne conditional branch
  task automatic test_branch();
    logic [4:0] seq [5] = '{F, F, F, D, BR};
    Opcode = 6'h05;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if (State !== seq[i] || PCWriteCond !== (i == 4)) begin
        fails++;
        $display("FAIL bne[%0d] state=%0d pwc=%b expected state=%0d pwc=%b", i, State, PCWriteCond, seq[i], i == 4);
      end
      if (i == 4) begin
        tests++;
        if (EQorNE !== 1'b1 || PCSrc !== 3'b001 || ALUOp !== 3'b111 || ALUSrcA !== 1'b1) begin
          fails++;
          $display("FAIL branch eqne=%b pcsrc=%b op=%b srca=%b expected 1 001 111 1", EQorNE, PCSrc, ALUOp, ALUSrcA);
        end
      end
    end
  endtask
  // reset asserted during the second MEM_WR cycle aborts the store
  task automatic test_reset_mid_store();
    logic [4:0] seq [7] = '{F, F, F, D, AD, MW, MW};
    logic [4:0] post [5] = '{F, F, F, D, JP};
    Opcode = 6'h2B;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      tests++;
      if (State !== seq[i]) begin
        fails++;
        $display("FAIL abort_sw[%0d] state=%0d expected %0d", i, State, seq[i]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (State !== RST || MemRead_Write !== 1'b0 || strobes !== 9'd0) begin
      fails++;
      $display("FAIL abort_reset state=%0d mrw=%b strobes=%b expected 0 0 0", State, MemRead_Write, strobes);
    end
    rst = 1'b1;
    Opcode = 6'h02;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if (State !== post[i] || IRWrite !== (i == 2) || MemRead_Write !== 1'b0 || RegWrite !== 1'b0) begin
        fails++;
        $display("FAIL abort_refetch[%0d] state=%0d ir=%b mrw=%b expected state=%0d ir=%b", i, State, IRWrite, MemRead_Write, post[i], i == 2);
      end
    end
  endtask
  initial begin
    test_reset();
    test_rtype(6'h20, 1'b0, 3'b001);
    test_rtype(6'h24, 1'b1, 3'b011);
    test_exception(6'h08, 1'b1, 1'b0);
    test_mem();
    test_branch();
    test_exception(6'h3F, 1'b0, 1'b1);
    test_reset_mid_store();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/main_control_fsm.md
Name: main_control_fsm

Overview:
Multicycle main control unit for the MIPS-subset datapath. A Moore FSM that decodes Opcode/Funct from the instruction register and drives every mux select, register load and write strobe of the datapath: PC, memory, IR, register bank, A/B, ALU, ALUOut and EPC. It sequences fetch, decode, execute, memory and writeback, plus the overflow and invalid-opcode exception paths.

Parameters:
MEM_WAIT, 2, extra wait cycles after a memory address is presented before read data or a write is valid (0..3)
EXC_VEC_SEL, 3'b101, PCSrc code that selects the exception vector

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-low
Opcode  in  6  IR[31:26]
Funct  in  6  IR[5:0]
Overflow  in  1  ALU overflow, combinational
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  PC load gated externally by Igual and EQorNE
EQorNE  out  1  0=beq, 1=bne
IorD  out  3  memory address: 000 PC, 001 ALUOut
MemRead_Write  out  1  0 read, 1 write
IRWrite  out  1  IR load
RegWrite  out  1  register bank write
RegDst  out  2  00 rt, 01 rd
MemtoReg  out  4  0000 ALUOut, 0001 MDR
RegALoad, RegBLoad  out  1 each  A/B load
ALUSrcA  out  1  0 PC, 1 A
ALUSrcB  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 imm<<2
ALUOp  out  3  Ula32 code: 001 add, 010 sub, 011 and, 111 compare
ALUOutLoad  out  1  ALUOut load
EPCWrite  out  1  EPC load from ALU_Out
PCSrc  out  3  000 ALU_Out, 001 ALUOut, 010 jump target, EXC_VEC_SEL exception vector
ExcCause  out  1  0 overflow, 1 invalid opcode; valid while in EXC2
State  out  5  current state, debug only

Behaviour:
- All outputs are decoded from state (Moore). Any output not listed for a state is 0. This includes the selects, so IorD=000, PCSrc=000 etc.
- Reset: rst=0 at a clock edge forces state RESET regardless of current state; all strobes are 0 in the following cycle. A reset in the middle of an instruction aborts it, with no partial write. RESET lasts 1 cycle, then FETCH.
- FETCH (MEM_WAIT+1 cycles, internal counter): IorD=000, MemRead_Write=0. On the final cycle only: IRWrite=1, PCWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=001, PCSrc=000. Then DECODE.
- DECODE (1 cycle): RegALoad=RegBLoad=1, ALUSrcA=0, ALUSrcB=11, ALUOp=001, ALUOutLoad=1. Next state by opcode:
  - 0x00 with Funct 0x20/0x22/0x24 -> EXEC_R; any other R-type funct -> EXC1
  - 0x08 addi -> EXEC_I
  - 0x23 lw or 0x2B sw -> ADDR
  - 0x04/0x05 -> BRANCH
  - 0x02 -> JUMP
  - any other opcode -> EXC1 with cause=1
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=add/sub/and from Funct, ALUOutLoad=1. Next state WB_R, or EXC1 with cause=0 if Overflow=1 during this cycle for add/sub. and never traps.
- WB_R: RegDst=01, MemtoReg=0000, RegWrite=1 -> FETCH.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=001, ALUOutLoad=1. Overflow -> EXC1 (cause=0), else WB_I.
- WB_I: RegDst=00, MemtoReg=0000, RegWrite=1 -> FETCH.
- ADDR: as EXEC_I but never traps -> MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: MEM_WAIT+1 cycles, IorD=001, read -> WB_LW.
- WB_LW: RegDst=00, MemtoReg=0001, RegWrite=1 -> FETCH.
- MEM_WR: MEM_WAIT+1 cycles, IorD=001, MemRead_Write=1 on every cycle -> FETCH.
- BRANCH (1 cycle): ALUSrcA=1, ALUSrcB=00, ALUOp=111, PCSrc=001, PCWriteCond=1, EQorNE=Opcode[0] -> FETCH.
- JUMP (1 cycle): PCSrc=010, PCWrite=1 -> FETCH.
- EXC1: ALUSrcA=0, ALUSrcB=01, ALUOp=010 (PC-4), EPCWrite=1 -> EXC2.
- EXC2: PCSrc=EXC_VEC_SEL, PCWrite=1, ExcCause held -> FETCH.
- The cause register is written only on entry to EXC1.
- No RegWrite is ever asserted on a trapping instruction.
- Overflow is ignored in all states other than EXEC_R (add/sub) and EXEC_I.

Test Plan:
- rst=0 for 2 cycles, then 1 -> all strobes 0, State=RESET for 1 cycle, then FETCH; IRWrite and PCWrite pulse exactly once, on cycle MEM_WAIT+1 of FETCH.
- add (Opcode 0, Funct 0x20), Overflow=0 -> FETCH, DECODE, EXEC_R (ALUOp=001), WB_R (RegWrite=1, RegDst=01); 4+MEM_WAIT cycles total.
- addi with Overflow=1 in EXEC_I -> EXC1 (EPCWrite=1, ALUOp=010), EXC2 (PCWrite=1, PCSrc=101, ExcCause=0); RegWrite never asserted.
- lw with MEM_WAIT=2 -> MEM_RD lasts 3 cycles with IorD=001, then WB_LW with MemtoReg=0001; sw -> MemRead_Write=1 for 3 cycles, no RegWrite.
- bne (0x05) -> BRANCH with PCWriteCond=1, EQorNE=1, PCSrc=001; Opcode 0x3F -> EXC1/EXC2 with ExcCause=1.
- rst=0 during MEM_WR cycle 2 -> next cycle State=RESET, MemRead_Write=0; the fetch after release is clean.
